// File: rtl/cache_stats_monitor_pkg.sv
// Shared definitions for the cache statistics monitor: counter selector
// encoding and the number of counters kept per channel.
package cachepkg;

  typedef enum logic [2:0] {
    READS   = 3'd0,
    WRITES  = 3'd1,
    RD_HITS = 3'd2,
    WR_HITS = 3'd3,
    MISSES  = 3'd4,
    EVICTS  = 3'd5
  } ctr_sel_e;

  localparam int unsigned NUM_CTRS = 6;

  function automatic logic ctr_valid(input logic [2:0] sel);
    return 32'(sel) < NUM_CTRS;
  endfunction

endpackage

// File: rtl/cache_stats_monitor_stats_counter.sv
// Saturating statistic counter. count_next exposes the value the counter
// would load this edge so a snapshot can capture the in-flight increment.
module stats_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] count_next,
  output logic                 sat
);

  logic at_max;

  assign at_max     = &count;
  assign sat        = inc & at_max;
  assign count_next = (inc & ~at_max) ? count + CNT_WIDTH'(1) : count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/cache_stats_monitor.sv
// Passive multi-channel cache statistics monitor: saturating per-channel
// event counters, optional windowed snapshot bank and a registered read port.
module cache_stats_monitor
  import cachepkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned WINDOW    = 0
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic [NUM_CH-1:0]                             ev_valid,
  input  logic [NUM_CH-1:0]                             ev_write,
  input  logic [NUM_CH-1:0]                             ev_hit,
  input  logic [NUM_CH-1:0]                             ev_evict,
  input  logic                                          clear,
  input  logic                                          freeze,
  input  logic                                          rd_req,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  input  logic [2:0]                                    rd_ctr,
  output logic                                          rd_valid,
  output logic [CNT_WIDTH-1:0]                          rd_data,
  output logic                                          rd_err,
  output logic                                          window_done,
  output logic [NUM_CH-1:0]                             sat_flag,
  output logic [NUM_CH-1:0]                             proto_err
);

  localparam int unsigned NC = NUM_CH * NUM_CTRS;

  logic [NUM_CH-1:0]                 acc;
  logic [NC-1:0]                     inc;
  logic [NC-1:0]                     sat;
  logic [NC-1:0][CNT_WIDTH-1:0]      live;
  logic [NC-1:0][CNT_WIDTH-1:0]      live_next;
  logic [NC-1:0][CNT_WIDTH-1:0]      bank;
  logic                              rollover;
  logic                              ctr_clr;
  logic                              rd_ok;
  int unsigned                       rd_idx;
  logic [CNT_WIDTH-1:0]              rd_word;

  assign acc     = ev_valid & {NUM_CH{~(freeze | clear)}};
  assign ctr_clr = clear | rollover;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Bit order follows ctr_sel_e: READS at the LSB, EVICTS at the MSB.
    assign inc[c*NUM_CTRS +: NUM_CTRS] = {
      acc[c] & ev_evict[c] & ~ev_hit[c],
      acc[c] & ~ev_hit[c],
      acc[c] & ev_write[c] & ev_hit[c],
      acc[c] & ~ev_write[c] & ev_hit[c],
      acc[c] & ev_write[c],
      acc[c] & ~ev_write[c]
    };

    for (genvar k = 0; k < NUM_CTRS; k++) begin : g_ctr
      stats_counter #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (inc[c*NUM_CTRS+k]),
        .clr       (ctr_clr),
        .count     (live[c*NUM_CTRS+k]),
        .count_next(live_next[c*NUM_CTRS+k]),
        .sat       (sat[c*NUM_CTRS+k])
      );
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag  <= '0;
      proto_err <= '0;
    end else if (clear) begin
      sat_flag  <= '0;
      proto_err <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (|sat[c*NUM_CTRS +: NUM_CTRS]) sat_flag[c] <= 1'b1;
      end
      proto_err <= proto_err | (acc & ev_evict & ev_hit);
    end
  end

  if (WINDOW > 0) begin : g_win
    localparam int unsigned TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [TW-1:0]                timer;
    logic [NC-1:0][CNT_WIDTH-1:0] snap;

    assign rollover = ~clear & ~freeze & (timer == TW'(WINDOW - 1));
    assign bank     = snap;

    // Snapshot takes count_next so an event on the rollover edge lands in
    // the closing window rather than being lost to the live clear.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        timer       <= '0;
        snap        <= '0;
        window_done <= 1'b0;
      end else begin
        window_done <= rollover;
        if (clear) begin
          timer <= '0;
          snap  <= '0;
        end else if (rollover) begin
          timer <= '0;
          snap  <= live_next;
        end else if (!freeze) begin
          timer <= timer + TW'(1);
        end
      end
    end
  end else begin : g_cum
    logic unused_next;

    assign unused_next = ^live_next;
    assign rollover    = 1'b0;
    assign window_done = 1'b0;
    assign bank        = live;
  end

  always_comb begin
    rd_ok   = (32'(rd_ch) < NUM_CH) && ctr_valid(rd_ctr);
    rd_idx  = 32'(rd_ch) * NUM_CTRS + 32'(rd_ctr);
    rd_word = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (rd_ok && (i == rd_idx)) rd_word = bank[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req & ~rd_ok;
      rd_data  <= rd_req ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_cache_stats_monitor.sv
// Scoreboard bench: a cumulative 3-channel 4-bit instance and a windowed
// 2-channel 8-bit instance, each with its own read-back monitor.
module tb_cache_stats_monitor;
  import cachepkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic [2:0] ev_valid_c = '0, ev_write_c = '0, ev_hit_c = '0, ev_evict_c = '0;
  logic       clear_c = 1'b0, freeze_c = 1'b0, rd_req_c = 1'b0;
  logic [1:0] rd_ch_c = '0;
  logic [2:0] rd_ctr_c = '0;
  logic       rd_valid_c, rd_err_c, window_done_c;
  logic [3:0] rd_data_c;
  logic [2:0] sat_flag_c, proto_err_c;

  logic [1:0] ev_valid_w = '0, ev_write_w = '0, ev_hit_w = '0, ev_evict_w = '0;
  logic       clear_w = 1'b0, freeze_w = 1'b0, rd_req_w = 1'b0;
  logic [0:0] rd_ch_w = '0;
  logic [2:0] rd_ctr_w = '0;
  logic       rd_valid_w, rd_err_w, window_done_w;
  logic [7:0] rd_data_w;
  logic [1:0] sat_flag_w, proto_err_w;

  cache_stats_monitor #(.NUM_CH(3), .CNT_WIDTH(4), .WINDOW(0)) dut_c (
    .clock(clock), .reset_n(reset_n),
    .ev_valid(ev_valid_c), .ev_write(ev_write_c), .ev_hit(ev_hit_c), .ev_evict(ev_evict_c),
    .clear(clear_c), .freeze(freeze_c), .rd_req(rd_req_c), .rd_ch(rd_ch_c), .rd_ctr(rd_ctr_c),
    .rd_valid(rd_valid_c), .rd_data(rd_data_c), .rd_err(rd_err_c),
    .window_done(window_done_c), .sat_flag(sat_flag_c), .proto_err(proto_err_c)
  );

  cache_stats_monitor #(.NUM_CH(2), .CNT_WIDTH(8), .WINDOW(8)) dut_w (
    .clock(clock), .reset_n(reset_n),
    .ev_valid(ev_valid_w), .ev_write(ev_write_w), .ev_hit(ev_hit_w), .ev_evict(ev_evict_w),
    .clear(clear_w), .freeze(freeze_w), .rd_req(rd_req_w), .rd_ch(rd_ch_w), .rd_ctr(rd_ctr_w),
    .rd_valid(rd_valid_w), .rd_data(rd_data_w), .rd_err(rd_err_w),
    .window_done(window_done_w), .sat_flag(sat_flag_w), .proto_err(proto_err_w)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] qc_data[$];
  logic       qc_err[$];
  string      qc_name[$];
  logic [7:0] qw_data[$];
  logic       qw_err[$];
  string      qw_name[$];

  logic req_c_d, req_w_d;
  int   exp2 [6] = '{5, 1, 3, 0, 3, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic rd_c(input int ch, input int ctr, input int exp, input logic err, input string name);
    rd_req_c = 1'b1;
    rd_ch_c  = 2'(ch);
    rd_ctr_c = 3'(ctr);
    qc_data.push_back(4'(exp));
    qc_err.push_back(err);
    qc_name.push_back(name);
    step();
    rd_req_c = 1'b0;
  endtask

  task automatic rd_w(input int ch, input int ctr, input int exp, input logic err, input string name);
    rd_req_w = 1'b1;
    rd_ch_w  = 1'(ch);
    rd_ctr_w = 3'(ctr);
    qw_data.push_back(8'(exp));
    qw_err.push_back(err);
    qw_name.push_back(name);
    step();
    rd_req_w = 1'b0;
  endtask

  task automatic ev_c(input int ch, input logic w, input logic h, input logic e);
    ev_valid_c = 3'(1) << ch;
    ev_write_c = w ? ev_valid_c : '0;
    ev_hit_c   = h ? ev_valid_c : '0;
    ev_evict_c = e ? ev_valid_c : '0;
    step();
    ev_valid_c = '0;
    ev_write_c = '0;
    ev_hit_c   = '0;
    ev_evict_c = '0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_c_d <= 1'b0;
      req_w_d <= 1'b0;
    end else begin
      req_c_d <= rd_req_c;
      req_w_d <= rd_req_w;
    end
  end

  always @(negedge clock) begin : mon_c
    string      n;
    logic [3:0] d;
    logic       e;
    if (reset_n) begin
      chk("rd_valid_c_latency", 32'(rd_valid_c), 32'(req_c_d));
      if (rd_valid_c) begin
        if (qc_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_c_unexpected: got data 0x%0h, expected no response", rd_data_c);
        end else begin
          n = qc_name.pop_front();
          d = qc_data.pop_front();
          e = qc_err.pop_front();
          chk({n, "_data"}, 32'(rd_data_c), 32'(d));
          chk({n, "_err"}, 32'(rd_err_c), 32'(e));
        end
      end else begin
        chk("idle_c", {27'd0, rd_err_c, rd_data_c}, 32'd0);
      end
    end
  end

  always @(negedge clock) begin : mon_w
    string      n;
    logic [7:0] d;
    logic       e;
    if (reset_n) begin
      chk("rd_valid_w_latency", 32'(rd_valid_w), 32'(req_w_d));
      if (rd_valid_w) begin
        if (qw_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_w_unexpected: got data 0x%0h, expected no response", rd_data_w);
        end else begin
          n = qw_name.pop_front();
          d = qw_data.pop_front();
          e = qw_err.pop_front();
          chk({n, "_data"}, 32'(rd_data_w), 32'(d));
          chk({n, "_err"}, 32'(rd_err_w), 32'(e));
        end
      end else begin
        chk("idle_w", {23'd0, rd_err_w, rd_data_w}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    step();
    step();
    chk("rst_rd_valid_c", 32'(rd_valid_c), 0);
    chk("rst_rd_data_c", 32'(rd_data_c), 0);
    chk("rst_sat_flag_c", 32'(sat_flag_c), 0);
    chk("rst_proto_err_c", 32'(proto_err_c), 0);
    chk("rst_window_done_w", 32'(window_done_w), 0);
    chk("rst_rd_valid_w", 32'(rd_valid_w), 0);
    reset_n = 1'b1;

    for (int ch = 0; ch < 3; ch++)
      for (int k = 0; k < 6; k++)
        rd_c(ch, k, 0, 1'b0, $sformatf("rst_ch%0d_ctr%0d", ch, k));

    // ch0: 3 read hits, 2 read misses (one evicting), 1 write miss
    for (int i = 0; i < 3; i++) ev_c(0, 1'b0, 1'b1, 1'b0);
    ev_c(0, 1'b0, 1'b0, 1'b0);
    ev_c(0, 1'b0, 1'b0, 1'b1);
    ev_c(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) rd_c(0, k, exp2[k], 1'b0, $sformatf("mix_ctr%0d", k));
    rd_c(1, READS, 0, 1'b0, "mix_ch1_reads");

    for (int i = 0; i < 17; i++) ev_c(1, 1'b0, 1'b0, 1'b0);
    chk("sat_flag_set", 32'(sat_flag_c), 32'b010);
    rd_c(1, READS, 15, 1'b0, "sat_reads");
    rd_c(1, MISSES, 15, 1'b0, "sat_misses");
    rd_c(1, WRITES, 0, 1'b0, "sat_writes");
    rd_c(0, READS, 5, 1'b0, "sat_ch0_reads");
    clear_c = 1'b1;
    step();
    clear_c = 1'b0;
    chk("sat_flag_cleared", 32'(sat_flag_c), 0);
    rd_c(1, READS, 0, 1'b0, "clr_ch1_reads");
    rd_c(0, READS, 0, 1'b0, "clr_ch0_reads");
    rd_c(0, EVICTS, 0, 1'b0, "clr_ch0_evicts");

    clear_c = 1'b1;
    ev_c(0, 1'b0, 1'b1, 1'b0);
    clear_c = 1'b0;
    ev_c(0, 1'b0, 1'b0, 1'b0);
    freeze_c = 1'b1;
    for (int i = 0; i < 4; i++) ev_c(0, 1'b1, 1'b1, 1'b0);
    freeze_c = 1'b0;
    rd_c(0, READS, 1, 1'b0, "frz_reads");
    rd_c(0, WRITES, 0, 1'b0, "frz_writes");
    rd_c(0, WR_HITS, 0, 1'b0, "frz_wr_hits");
    rd_c(0, MISSES, 1, 1'b0, "frz_misses");

    rd_c(0, 6, 0, 1'b1, "bad_ctr6");
    rd_c(2, 7, 0, 1'b1, "bad_ctr7");
    rd_c(3, READS, 0, 1'b1, "bad_ch3");
    rd_c(0, READS, 1, 1'b0, "after_bad");
    ev_c(1, 1'b0, 1'b1, 1'b1);
    chk("proto_err_set", 32'(proto_err_c), 32'b010);
    rd_c(1, READS, 1, 1'b0, "proto_reads");
    rd_c(1, RD_HITS, 1, 1'b0, "proto_rd_hits");
    rd_c(1, EVICTS, 0, 1'b0, "proto_evicts");
    rd_c(1, MISSES, 0, 1'b0, "proto_misses");

    // Windowed instance: clear aligns the timer, then one read per cycle.
    clear_w = 1'b1;
    step();
    clear_w = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      ev_valid_w = 2'b01;
      step();
      chk($sformatf("window_done_e%0d", i), 32'(window_done_w), 32'(i == 8 || i == 16));
    end
    ev_valid_w = '0;
    rd_w(0, READS, 8, 1'b0, "win_snap_reads");
    rd_w(1, READS, 0, 1'b0, "win_snap_ch1");
    step();
    chk("window_done_e23", 32'(window_done_w), 0);
    rd_w(0, READS, 8, 1'b0, "rollover_cycle_rd");
    chk("window_done_e24", 32'(window_done_w), 1);
    rd_w(0, READS, 4, 1'b0, "win_snap2_reads");
    freeze_w   = 1'b1;
    ev_valid_w = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("frz_window_done_%0d", i), 32'(window_done_w), 0);
    end
    freeze_w   = 1'b0;
    ev_valid_w = '0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("resume_window_done_%0d", i), 32'(window_done_w), 32'(i == 7));
    end
    rd_w(0, READS, 0, 1'b0, "frz_snap_reads");

    // Reset asserted while a read response is being presented.
    rd_req_c = 1'b1;
    rd_ch_c  = 2'd1;
    rd_ctr_c = 3'(READS);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_valid_c", 32'(rd_valid_c), 0);
    chk("async_rd_data_c", 32'(rd_data_c), 0);
    chk("async_rd_err_c", 32'(rd_err_c), 0);
    chk("async_proto_err_c", 32'(proto_err_c), 0);
    chk("async_window_done_w", 32'(window_done_w), 0);
    rd_req_c = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    rd_c(1, READS, 0, 1'b0, "post_rst_ch1_reads");
    rd_c(1, RD_HITS, 0, 1'b0, "post_rst_ch1_rd_hits");
    rd_c(0, READS, 0, 1'b0, "post_rst_ch0_reads");
    rd_w(0, READS, 0, 1'b0, "post_rst_w_snap");

    step();
    step();
    chk("window_done_c", 32'(window_done_c), 0);
    chk("drain_c", 32'(qc_data.size()), 0);
    chk("drain_w", 32'(qw_data.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
